hangman_word_state: RTL
=======================

# hangman_word_state

Parametrised game-state engine that replaces the hard-wired letter and miss-count constants feeding the VGA controller. It stores a target word of up to `NUM_LETTERS` characters, accepts one guessed letter per strobe, and tracks which positions are revealed, which letters were already tried and how many misses occurred. It also tracks win/lose status. Its packed outputs drive the VGA letter inputs and the `incorrect` input directly; the block sits between the input/keyboard logic and `vga640x480`, clocked by the same domain as the game logic.

## Interface
- `NUM_LETTERS`, 10, word positions; must be 1..16.
- `LETTER_W`, 8, bits per letter code. Code 0 means absent/blank; codes 1..26 mean A..Z; all other codes are invalid.
- `MAX_MISS`, 15, number of misses that ends the game; must be ≥1.
- `MISS_W`, `$clog2(MAX_MISS+1)`, width of the miss counter.

- `clk` input 1: game clock. One clock; all state is rising-edge.
- `clr` input 1: reset, asynchronous, active-high.
- `word_load` input 1: one-cycle strobe that loads `word_in` and starts a game.
- `word_in` input NUM_LETTERS*LETTER_W: target word; position 0 is in the LSBs.
- `guess_valid` input 1: guess strobe.
- `guess_letter` input LETTER_W: guessed code.
- `guess_ready` output 1: high only in PLAY.
- `letters_out` output NUM_LETTERS*LETTER_W: the stored code if that position is revealed, otherwise 0.
- `word_mask` output NUM_LETTERS: 1 where the stored code is non-zero.
- `incorrect` output MISS_W: miss count.
- `hit_pulse` output 1: one-cycle pulse on a hit.
- `miss_pulse` output 1: one-cycle pulse on a miss.
- `game_state` output 2: 00 IDLE, 01 PLAY, 10 WON, 11 LOST.

## Operation
- **Registers:**
  - word store: NUM_LETTERS×LETTER_W
  - `revealed`: NUM_LETTERS bits
  - `tried`: 26 bits, one per letter
  - miss counter: MISS_W bits
  - 2-bit state register
- **Load (any state):**
  - Latches `word_in`.
  - `revealed[i]` = 1 where the code is 0 (absent), and also where the code is invalid (27+); those positions are forced to 0 in the store.
  - Clears `tried` and the miss counter.
  - Next state is PLAY, or WON if all positions are absent.
- **Guess (PLAY only, `guess_valid`=1, `word_load`=0):**
  - Invalid code (0 or >26): ignored, no pulse.
  - Letter already in `tried`: ignored, no pulse, counter unchanged.
  - Otherwise set its `tried` bit, then test every position in parallel:
    - If any stored code matches: set those `revealed` bits and pulse `hit_pulse`.
    - If none matches: increment the miss counter and pulse `miss_pulse`.
- **Transitions:**
  - IDLE→PLAY (load), or IDLE→WON if the loaded word is empty.
  - PLAY→WON when `revealed` would become all-ones.
  - PLAY→LOST when the counter would reach MAX_MISS.
  - WON/LOST hold until the next load.
  - Guesses in IDLE, WON or LOST are ignored.
- **Saturation:** the counter never exceeds MAX_MISS; no wrap.
- **Simultaneous events:**
  - `word_load` and `guess_valid` in the same cycle: the load wins and the guess is discarded with no pulse.
  - A single guess that reveals the last letters yields WON even if that cycle's counter is at MAX_MISS−1 (a hit cannot be a miss).

## Timing
- **Reset values** (while `clr`=1, asynchronously):
  - `game_state`=IDLE
  - `letters_out`=0, `word_mask`=0, `incorrect`=0
  - `hit_pulse`=0, `miss_pulse`=0, `guess_ready`=0
  - `revealed`=0, `tried`=0
- **Latency:** a guess sampled at edge T updates `letters_out`, `incorrect`, the pulses and `game_state` together, visible after edge T.
  - `hit_pulse`/`miss_pulse` are high for exactly the cycle after T.
  - Outputs are registered, apart from masking of the store.
- **Load latency:** a load at edge T gives new `word_mask`, cleared outputs and the new state after T.
- **Throughput:** back-to-back guesses are accepted every cycle; each guess sees the `tried`/`revealed` values updated by the previous one.
- **`guess_ready`:** a decode of the registered state; it goes low in the cycle after the winning or losing guess.
- **Reset mid-game:** `clr` asserted at any phase returns everything to the reset values immediately; a strobe in the same cycle is lost.

## Test plan
- **Reset:** hold `clr` for 3 cycles while strobing `guess_valid`. All outputs stay 0 and `game_state`=00; the first load after release gives PLAY.
- **Hit/duplicate:** load "HELLO" (8,5,12,12,15, rest 0), then guess 12.
  - Positions 2 and 3 show 12; `hit_pulse`=1 for 1 cycle; `incorrect`=0.
  - Repeating 12 gives no pulse and no change.
- **Lose:** with MAX_MISS=3, load "AB" and guess 3, 4, 5 on consecutive cycles.
  - `incorrect` reads 1, 2, 3; three `miss_pulse` cycles; state=LOST after the third guess.
  - A further guess of 1 reveals nothing.
- **Win:** load "AB" and guess 1 then 2. After the second guess `letters_out` low bytes are 01,02; state=WON; `guess_ready`=0.
- **Collisions:**
  - `word_load` and `guess_valid` in the same cycle: the guess is dropped and `tried`=0.
  - Loading an all-zero word gives WON after one edge.
  - Guesses of codes 0 and 27 produce no pulses.
- **Saturation/parameters:** with NUM_LETTERS=16 and MAX_MISS=1, the first miss gives LOST with `incorrect`=1; further guesses are ignored and the counter stays 1.

Source files
------------

// File: rtl/hangman_word_state.sv
// Hangman game-state engine: word store, per-position reveal, tried-letter set,
// saturating miss counter and IDLE/PLAY/WON/LOST state, feeding the VGA letter inputs.

module hangman_lane #(
    parameter int LETTER_W = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                load,
    input  logic [LETTER_W-1:0] code_in,
    input  logic                accept,
    input  logic [LETTER_W-1:0] guess_letter,
    output logic [LETTER_W-1:0] code,
    output logic                revealed,
    output logic                match,
    output logic                load_blank
);
    // Invalid codes are treated as absent so they never block a win.
    assign load_blank = (code_in == '0) || (code_in > LETTER_W'(26));
    assign match      = (code != '0) && (code == guess_letter);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            code     <= '0;
            revealed <= 1'b0;
        end else if (load) begin
            code     <= load_blank ? '0 : code_in;
            revealed <= load_blank;
        end else if (accept && match) begin
            revealed <= 1'b1;
        end
    end
endmodule

module hangman_word_state #(
    parameter int NUM_LETTERS = 10,
    parameter int LETTER_W    = 8,
    parameter int MAX_MISS    = 15,
    parameter int MISS_W      = $clog2(MAX_MISS + 1)
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            word_load,
    input  logic [NUM_LETTERS*LETTER_W-1:0] word_in,
    input  logic                            guess_valid,
    input  logic [LETTER_W-1:0]             guess_letter,
    output logic                            guess_ready,
    output logic [NUM_LETTERS*LETTER_W-1:0] letters_out,
    output logic [NUM_LETTERS-1:0]          word_mask,
    output logic [MISS_W-1:0]               incorrect,
    output logic                            hit_pulse,
    output logic                            miss_pulse,
    output logic [1:0]                      game_state
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_WON = 2'b10, S_LOST = 2'b11} state_t;

    state_t                                state, state_d;
    logic [NUM_LETTERS-1:0][LETTER_W-1:0]  word_a, code_a, letters_a;
    logic [NUM_LETTERS-1:0]                revealed, match, load_blank;
    logic [25:0]                           tried, letter_oh;
    logic [4:0]                            letter_idx;
    logic [MISS_W-1:0]                     miss_cnt;
    logic                                  letter_ok, guess_ok, any_hit;

    assign word_a     = word_in;
    assign letter_ok  = (guess_letter != '0) && (guess_letter <= LETTER_W'(26));
    assign letter_idx = guess_letter[4:0] - 5'd1;
    assign letter_oh  = 26'd1 << letter_idx;
    assign guess_ok   = (state == S_PLAY) && guess_valid && !word_load && letter_ok
                        && ((tried & letter_oh) == '0);
    assign any_hit    = |match;

    for (genvar i = 0; i < NUM_LETTERS; i++) begin : g_lane
        hangman_lane #(.LETTER_W(LETTER_W)) u_lane (
            .clk         (clk),
            .clr         (clr),
            .load        (word_load),
            .code_in     (word_a[i]),
            .accept      (guess_ok),
            .guess_letter(guess_letter),
            .code        (code_a[i]),
            .revealed    (revealed[i]),
            .match       (match[i]),
            .load_blank  (load_blank[i])
        );
        assign letters_a[i] = revealed[i] ? code_a[i] : '0;
        assign word_mask[i] = (code_a[i] != '0);
    end

    assign letters_out = letters_a;
    assign incorrect   = miss_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_d;
    end

    // A hit is checked for a win first, so a last-letter hit never counts toward LOST.
    always_comb begin
        state_d = state;
        if (word_load)
            state_d = (&load_blank) ? S_WON : S_PLAY;
        else if (guess_ok) begin
            if (any_hit) begin
                if (&(revealed | match)) state_d = S_WON;
            end else if (miss_cnt >= MISS_W'(MAX_MISS - 1)) begin
                state_d = S_LOST;
            end
        end
    end

    always_comb begin
        guess_ready = (state == S_PLAY);
        game_state  = state;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tried      <= '0;
            miss_cnt   <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= guess_ok && any_hit;
            miss_pulse <= guess_ok && !any_hit;
            if (word_load) begin
                tried    <= '0;
                miss_cnt <= '0;
            end else if (guess_ok) begin
                tried <= tried | letter_oh;
                if (!any_hit && miss_cnt != MISS_W'(MAX_MISS))
                    miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
endmodule
